// File: rtl/mmio_uart_tx_fifo.sv
// MMIO UART transmitter: CPU-written bytes are queued in a DEPTH-entry FIFO and serialized 8N1/8N2.
// Latency: register reads return one cycle after the request; a queued byte starts its frame one cycle after it is seen.
// Backpressure: none on the bus (cmd_ready tied high); pushes into a full FIFO are dropped and flagged as overflow.
module mmio_uart_tx_fifo #(
  parameter int FMAX_MHz  = 27,
  parameter int BAUD      = 115200,
  parameter int DEPTH     = 64,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        uart_tx,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
  input  logic [31:0] input_wdata,
  output logic        output_irq
);

  localparam int AW      = $clog2(DEPTH);
  localparam int DEF_DIV = FMAX_MHz * 1000000 / BAUD;
  // A zero-cycle bit time is meaningless; clamp the reset value like a software write of 0.
  localparam logic [15:0] DIV_RST = (DEF_DIV < 1) ? 16'd1 : 16'(DEF_DIV);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [8:0] DEPTH_CNT = 9'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [8:0]    count;
  logic          overflow;
  logic [15:0]   divider;

  // Serializer state
  state_t      state;
  state_t      state_nxt;
  logic [16:0] cyc_cnt;
  logic [16:0] bit_lim;
  logic        bit_done;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [15:0] d_lat;

  // Bus decode
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  sel;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic        empty;
  logic        busy;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign wr_en    = input_cmd_start & input_cmd_write;
  assign rd_en    = input_cmd_start & ~input_cmd_write;
  assign sel      = input_addr[3:2];
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == 9'd0);
  assign busy     = (state != S_IDLE);
  assign pop      = (state == S_IDLE) && !empty;
  assign push_req = wr_en && (sel == 2'd0);
  // When full, a pop in the same cycle frees the slot the new byte needs.
  assign push_ok  = push_req && (!full || pop);

  assign output_cmd_ready = 1'b1;
  assign output_irq       = empty & ~busy;
  assign unused_bits      = ^{input_addr[31:4], input_addr[1:0], input_wdata[31:16]};

  // Stop phase spans STOP_BITS bit times; every other phase is one bit time.
  assign bit_lim  = (state == S_STOP) ?
                    ((STOP_BITS == 2) ? ({d_lat, 1'b0} - 17'd1) : ({1'b0, d_lat} - 17'd1)) :
                    ({1'b0, d_lat} - 17'd1);
  assign bit_done = (cyc_cnt == bit_lim);

  // Register read mux, sampled from the state in the request cycle
  always_comb begin
    rd_mux = 32'd0;
    case (sel)
      2'd1:    rd_mux = {15'd0, count, 4'd0, overflow, busy, empty, full};
      2'd2:    rd_mux = {16'd0, divider};
      default: rd_mux = 32'd0;
    endcase
  end

  // FIFO byte storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= input_wdata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= 9'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PTR_ONE;
      if (pop)     head <= head + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + 9'd1;
        2'b01:   count <= count - 9'd1;
        default: count <= count;
      endcase
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (wr_en && (sel == 2'd1) && input_wdata[3])
        overflow <= 1'b0;
    end
  end

  // Baud divider register; a write of 0 is stored as 1
  always_ff @(posedge clk) begin
    if (reset)
      divider <= DIV_RST;
    else if (wr_en && (sel == 2'd2))
      divider <= (input_wdata[15:0] == 16'd0) ? 16'd1 : input_wdata[15:0];
  end

  // Registered read response, one cycle after the request
  always_ff @(posedge clk) begin
    if (reset) begin
      output_rdata       <= 32'd0;
      output_rdata_valid <= 1'b0;
    end else begin
      output_rdata_valid <= rd_en;
      if (rd_en) output_rdata <= rd_mux;
    end
  end

  // Serializer state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Serializer next state and line level
  always_comb begin
    state_nxt = state;
    uart_tx   = 1'b1;
    case (state)
      S_IDLE: begin
        uart_tx = 1'b1;
        if (pop) state_nxt = S_START;
      end
      S_START: begin
        uart_tx = 1'b0;
        if (bit_done) state_nxt = S_DATA;
      end
      S_DATA: begin
        uart_tx = shreg[0];
        if (bit_done && (bit_idx == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        uart_tx = 1'b1;
        if (bit_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Serializer datapath: bit-time counter, bit index and shift register.
  // The divider is latched at frame start so mid-frame writes only affect the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= 17'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      d_lat   <= DIV_RST;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg   <= mem[head];
            d_lat   <= divider;
            cyc_cnt <= 17'd0;
            bit_idx <= 3'd0;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cyc_cnt <= 17'd0;
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cyc_cnt <= cyc_cnt + 17'd1;
          end
        end
        default: begin
          cyc_cnt <= bit_done ? 17'd0 : (cyc_cnt + 17'd1);
        end
      endcase
    end
  end

endmodule
